// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer: walks the instruction ROM, resolves
// sbf*/b branches against the flag register and Z/N, and frames a Start/Done run.
module fetch_sequencer #(
    parameter int          PW         = 10,
    parameter logic [8:0]  HALT_INSTR = 9'h1FF,
    parameter int          CW         = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [8:0]    Instr,
    input  logic          Branch,
    input  logic          FlagWrite,
    input  logic [2:0]    Flag,
    input  logic          CmpWrite,
    input  logic          Zero,
    input  logic          Neg,
    input  logic [PW-1:0] Target,
    output logic [PW-1:0] InstrAddr,
    output logic          Running,
    output logic          Done,
    output logic          Overflow,
    output logic [2:0]    FlagReg,
    output logic [CW-1:0] CycleCount
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [2:0]    flag_q, flag_d;
    logic          z_q, z_d;
    logic          n_q, n_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          taken;

    // Condition uses registered Z/N, so a compare in the same cycle as b is not yet visible.
    always_comb begin
        case (flag_q)
            3'b000:  taken = !z_q;
            3'b001:  taken = z_q;
            3'b010:  taken = n_q;
            3'b011:  taken = n_q | z_q;
            3'b100:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Handshake: a Start pulse in IDLE or DONE launches a run from address 0;
    // Done rises when the run ends (halt or PC overflow) and stays high until the next Start.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flag_d  = flag_q;
        z_d     = z_q;
        n_d     = n_q;
        ovf_d   = ovf_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    cyc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_RUN: begin
                cyc_d = (cyc_q == {CW{1'b1}}) ? cyc_q : cyc_q + CW'(1);
                if (CmpWrite) begin
                    z_d = Zero;
                    n_d = Neg;
                end
                if (Instr == HALT_INSTR) begin
                    state_d = S_DONE;
                end else if (Branch && !FlagWrite && taken) begin
                    pc_d = Target;
                end else begin
                    if (Branch && FlagWrite) begin
                        flag_d = Flag;
                    end
                    // Sequential fetch past the last ROM word ends the run instead of wrapping.
                    if (pc_q == {PW{1'b1}}) begin
                        state_d = S_DONE;
                        ovf_d   = 1'b1;
                    end else begin
                        pc_d = pc_q + PW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            flag_q  <= 3'b100;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            ovf_q   <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flag_q  <= flag_d;
            z_q     <= z_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
            cyc_q   <= cyc_d;
        end
    end

    assign InstrAddr  = pc_q;
    assign Running    = (state_q == S_RUN);
    assign Done       = (state_q == S_DONE);
    assign Overflow   = ovf_q;
    assign FlagReg    = flag_q;
    assign CycleCount = cyc_q;

endmodule
